// File: rtl/pipeline_if_stage1.sv
// Instruction fetch stage: owns the fetch PC, runs a single-outstanding req/gnt/rvalid
// handshake to instruction memory and buffers responses ahead of the decode stage.
module pipeline_if_stage1 #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IF,
  output logic [63:0] pc_IFR,
  output logic        if_valid
);

  // state | meaning
  // REQ   | request pending (asserted while the buffer has room)
  // WAIT  | granted, awaiting rvalid; data will be delivered
  // DRAIN | granted, awaiting rvalid; data will be discarded (redirected)
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  state_e        state_q, state_d;
  logic [63:0]   pc_fetch_q, pc_fetch_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic [31:0]   inst_q, inst_d;
  logic [63:0]   pc_ifr_q, pc_ifr_d;
  logic          valid_q, valid_d;

  logic [63:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          fetch_req;
  logic          deliver;
  logic          push;
  logic          pop;

  always_comb begin
    state_d    = state_q;
    pc_fetch_d = pc_fetch_q;
    req_pc_d   = req_pc_q;
    fetch_req  = 1'b0;
    deliver    = 1'b0;
    case (state_q)
      S_REQ: begin
        fetch_req = !reset && (count_q < DEPTH_C);
        if (fetch_req && imem_gnt) begin
          req_pc_d   = pc_fetch_q;
          pc_fetch_d = pc_fetch_q + 64'd4;
          state_d    = redirect_valid ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          deliver = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    // Redirect overrides any increment, so a discarded grant never advances the PC.
    if (redirect_valid) pc_fetch_d = {redirect_pc[63:2], 2'b00};
  end

  always_comb begin
    inst_d   = inst_q;
    pc_ifr_d = pc_ifr_q;
    valid_d  = valid_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (redirect_valid) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (count_q != '0) begin
        inst_d   = fifo_inst_q[rd_ptr_q];
        pc_ifr_d = fifo_pc_q[rd_ptr_q];
        valid_d  = 1'b1;
        pop      = 1'b1;
        push     = deliver;
      end else if (deliver) begin
        inst_d   = imem_rdata;
        pc_ifr_d = req_pc_q;
        valid_d  = 1'b1;
      end else begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    end else begin
      push = deliver;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_fetch_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inst_q     <= NOP_INST;
      pc_ifr_q   <= 64'd0;
      valid_q    <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_fetch_q <= pc_fetch_d;
      req_pc_q   <= req_pc_d;
      inst_q     <= inst_d;
      pc_ifr_q   <= pc_ifr_d;
      valid_q    <= valid_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      fifo_inst_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req       = fetch_req;
  assign imem_addr      = pc_fetch_q;
  assign instruction_IF = inst_q;
  assign pc_IFR         = pc_ifr_q;
  assign if_valid       = valid_q;

endmodule

// File: tb/tb_pipeline_if_stage1.sv
// Directed bench for pipeline_if_stage1: memory handshake driven step by step.
module tb_pipeline_if_stage1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_IF;
  logic [63:0] pc_IFR;
  logic        if_valid;

  int n_cmp;
  int n_fail;
  logic [31:0] w [0:10];

  pipeline_if_stage1 dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instruction_IF (instruction_IF),
    .pc_IFR         (pc_IFR),
    .if_valid       (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Grant immediately, respond one cycle later.
  task automatic fetch(input logic [31:0] word);
    imem_gnt = 1'b1;
    cyc;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    cyc;
    imem_rvalid = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i <= 10; i++) w[i] = 32'hA500_0000 + 32'(i * 32'h111);
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'd0;

    // T1: reset and release
    repeat (3) cyc;
    chk("rst_req",   64'(imem_req), 64'd0);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_inst",  64'(instruction_IF), 64'(NOP));
    chk("rst_pc",    pc_IFR, 64'd0);
    reset = 1'b0;
    #1;
    chk("t1_req",  64'(imem_req), 64'd1);
    chk("t1_addr", imem_addr, 64'h8000_0000);

    // T2: back-to-back fetches
    for (int i = 0; i < 4; i++) begin
      chk("t2_req",  64'(imem_req), 64'd1);
      chk("t2_addr", imem_addr, 64'h8000_0000 + 64'(4 * i));
      fetch(w[i]);
      chk("t2_inst",  64'(instruction_IF), 64'(w[i]));
      chk("t2_pc",    pc_IFR, 64'h8000_0000 + 64'(4 * i));
      chk("t2_valid", 64'(if_valid), 64'd1);
    end

    // T3: stall for 10 cycles, buffer fills, then drains in order
    stall = 1'b1;
    fetch(w[4]);
    chk("t3_hold_inst", 64'(instruction_IF), 64'(w[3]));
    fetch(w[5]);
    chk("t3_hold_pc",   pc_IFR, 64'h8000_000C);
    chk("t3_req_full",  64'(imem_req), 64'd0);
    chk("t3_valid",     64'(if_valid), 64'd1);
    imem_gnt = 1'b1;
    repeat (6) cyc;
    imem_gnt = 1'b0;
    chk("t3_addr_hold", imem_addr, 64'h8000_0018);
    chk("t3_req_still", 64'(imem_req), 64'd0);
    chk("t3_inst_hold", 64'(instruction_IF), 64'(w[3]));
    stall = 1'b0;
    cyc;
    chk("t3_pop0_inst", 64'(instruction_IF), 64'(w[4]));
    chk("t3_pop0_pc",   pc_IFR, 64'h8000_0010);
    cyc;
    chk("t3_pop1_inst", 64'(instruction_IF), 64'(w[5]));
    chk("t3_pop1_pc",   pc_IFR, 64'h8000_0014);
    chk("t3_pop1_vld",  64'(if_valid), 64'd1);
    cyc;
    chk("t3_empty_vld",  64'(if_valid), 64'd0);
    chk("t3_empty_inst", 64'(instruction_IF), 64'(NOP));
    chk("t3_empty_pc",   pc_IFR, 64'h8000_0014);

    // T4: redirect while waiting for data
    imem_gnt = 1'b1;
    cyc;
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    cyc;
    redirect_valid = 1'b0;
    chk("t4_drain_req",  64'(imem_req), 64'd0);
    chk("t4_drain_addr", imem_addr, 64'h8000_0100);
    cyc;
    cyc;
    chk("t4_drain_req2", 64'(imem_req), 64'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    cyc;
    imem_rvalid = 1'b0;
    chk("t4_drop_vld",  64'(if_valid), 64'd0);
    chk("t4_drop_inst", 64'(instruction_IF), 64'(NOP));
    chk("t4_req",       64'(imem_req), 64'd1);
    chk("t4_addr",      imem_addr, 64'h8000_0100);
    fetch(w[6]);
    chk("t4_new_inst", 64'(instruction_IF), 64'(w[6]));
    chk("t4_new_pc",   pc_IFR, 64'h8000_0100);
    chk("t4_new_vld",  64'(if_valid), 64'd1);

    // T5: redirect coincident with rvalid under stall, with a buffered word
    stall = 1'b1;
    fetch(w[7]);
    chk("t5_hold_inst", 64'(instruction_IF), 64'(w[6]));
    imem_gnt = 1'b1;
    cyc;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = w[8];
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    cyc;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    chk("t5_vld",  64'(if_valid), 64'd0);
    chk("t5_inst", 64'(instruction_IF), 64'(NOP));
    chk("t5_req",  64'(imem_req), 64'd1);
    chk("t5_addr", imem_addr, 64'h8000_0200);
    stall = 1'b0;
    cyc;
    chk("t5_flush_vld",  64'(if_valid), 64'd0);
    chk("t5_flush_inst", 64'(instruction_IF), 64'(NOP));

    // Redirect on the same cycle as a grant
    imem_gnt       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    cyc;
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    chk("t5b_req",  64'(imem_req), 64'd0);
    chk("t5b_addr", imem_addr, 64'h8000_0300);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    cyc;
    imem_rvalid = 1'b0;
    chk("t5b_vld",   64'(if_valid), 64'd0);
    chk("t5b_req2",  64'(imem_req), 64'd1);
    chk("t5b_addr2", imem_addr, 64'h8000_0300);

    // Redirect while requesting without grant re-targets the request
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0402;
    cyc;
    redirect_valid = 1'b0;
    chk("t5c_addr", imem_addr, 64'h8000_0400);
    chk("t5c_req",  64'(imem_req), 64'd1);
    fetch(w[9]);
    chk("t5c_inst", 64'(instruction_IF), 64'(w[9]));
    chk("t5c_pc",   pc_IFR, 64'h8000_0400);

    // T6: reset while waiting; late response must be ignored
    imem_gnt = 1'b1;
    cyc;
    imem_gnt = 1'b0;
    reset    = 1'b1;
    #1;
    chk("t6_rst_req", 64'(imem_req), 64'd0);
    cyc;
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    #1;
    chk("t6_req", 64'(imem_req), 64'd1);
    imem_gnt = 1'b0;
    cyc;
    imem_rvalid = 1'b0;
    chk("t6_vld",  64'(if_valid), 64'd0);
    chk("t6_inst", 64'(instruction_IF), 64'(NOP));
    chk("t6_pc",   pc_IFR, 64'd0);
    chk("t6_addr", imem_addr, 64'h8000_0000);
    fetch(w[10]);
    chk("t6_new_inst", 64'(instruction_IF), 64'(w[10]));
    chk("t6_new_pc",   pc_IFR, 64'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
